// File: rtl/encoder_8_3_pending.sv
// Sequential 8-to-3 encoder. It captures request lines into a pending register and serves one index at a time over Valid/Ready.
// Build option ENC_ROUND_ROBIN_EN: round-robin selection instead of fixed priority (HIGH_FIRST).
module encoder_8_3_pending #(
    parameter int HIGH_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       E,
    input  logic [7:0] In,
    input  logic       Ready,
    output logic       Valid,
    output logic [2:0] Out,
    output logic [7:0] Pending
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [2:0] out_q, out_d;
    logic [7:0] served;
    logic [7:0] rem;
    logic       accept;
    logic [2:0] sel_pend;
    logic [2:0] sel_rem;

`ifdef ENC_ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d;

    // The search starts one past ptr and wraps. ptr itself is checked last.
    function automatic logic [2:0] sel_rr(input logic [7:0] v, input logic [2:0] ptr);
        logic [2:0] idx;
        logic [2:0] cand;
        idx = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            cand = ptr + 3'(k);
            if (v[cand]) begin
                idx = cand;
            end
        end
        return idx;
    endfunction
`else
    function automatic logic [2:0] sel_fixed(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (HIGH_FIRST != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) begin
                    idx = 3'(i);
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) begin
                    idx = 3'(i);
                end
            end
        end
        return idx;
    endfunction
`endif

    function automatic logic [7:0] onehot3(input logic [2:0] idx);
        logic [7:0] v;
        v = 8'h00;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign accept = (state_q == S_PRESENT) && Ready;
    assign served = accept ? onehot3(out_q) : 8'h00;
    assign rem    = pend_q & ~served;
    // A bit that is set again on the same edge it is cleared stays pending.
    assign pend_d = rem | (E ? In : 8'h00);

`ifdef ENC_ROUND_ROBIN_EN
    assign ptr_d    = accept ? out_q : ptr_q;
    assign sel_pend = sel_rr(pend_q, ptr_q);
    assign sel_rem  = sel_rr(rem, ptr_d);
`else
    assign sel_pend = sel_fixed(pend_q);
    assign sel_rem  = sel_fixed(rem);
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q != 8'h00) begin
                    out_d   = sel_pend;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (Ready) begin
                    // Requests that arrive on the final acceptance edge are served from IDLE.
                    if (rem != 8'h00) begin
                        out_d = sel_rem;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= 8'h00;
            out_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
        end
    end

`ifdef ENC_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 3'd7;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign Valid   = (state_q == S_PRESENT);
    assign Out     = out_q;
    assign Pending = pend_q;

endmodule
